// File: rtl/ysyx_22050854_ifu_fetch.sv
// Instruction fetch: PC register, one outstanding imem read, {pc,inst} handed to decode; optional misaligned-target fault via `YSYX_22050854_IFU_MISALIGN_EN.
// Latency: request accepted at t, response at t+k, out_valid at t+k+1; next request the cycle after the output handshake.
// Backpressure: request held stable until imem_req_ready; output held until out_ready; no new fetch while output is held.
module ysyx_22050854_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr;
  logic        drop, drop_nxt;
  logic        deliver;
  logic        fault;

  always_comb begin
    state_nxt = state;
    pc_nxt    = redirect_valid ? redirect_pc : pc;
    drop_nxt  = drop;
    deliver   = 1'b0;
    fault     = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        // the issued address cannot change under valid, so a redirect here poisons its response
        if (redirect_valid) drop_nxt = 1'b1;
        if (imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) drop_nxt = 1'b1;
        if (imem_resp_valid) begin
          if (drop || redirect_valid) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            deliver   = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_nxt = S_REQ;
        end else if (out_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef YSYX_22050854_IFU_MISALIGN_EN
    // a misaligned fetch address is reported to decode instead of being requested
    if (state_nxt == S_REQ && state != S_REQ && pc_nxt[1:0] != 2'b00) begin
      state_nxt = S_HOLD;
      fault     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      req_addr <= RESET_PC;
      out_pc   <= 32'd0;
      out_inst <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      // address tracks the PC everywhere except while a request is on the bus
      if (state != S_REQ) req_addr <= pc_nxt;
      if (deliver) begin
        out_pc   <= pc;
        out_inst <= imem_resp_data;
      end else if (fault) begin
        out_pc   <= pc_nxt;
        out_inst <= '0;
      end
    end
  end

`ifdef YSYX_22050854_IFU_MISALIGN_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    fault_q <= 1'b0;
    else if (deliver)                              fault_q <= 1'b0;
    else if (fault)                                fault_q <= 1'b1;
    else if (state == S_HOLD && state_nxt != S_HOLD) fault_q <= 1'b0;
  end
  assign out_fault = fault_q;
`else
  assign out_fault = 1'b0;
`endif

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = req_addr;
  assign out_valid      = (state == S_HOLD);

endmodule

// File: tb/tb_ysyx_22050854_ifu_fetch.sv
// Bench for ysyx_22050854_ifu_fetch: architectural-PC model plus memory responder, directed cases then random traffic.
module tb_ysyx_22050854_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef YSYX_22050854_IFU_MISALIGN_EN
  localparam bit MISAL_EN = 1'b1;
`else
  localparam bit MISAL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  ysyx_22050854_ifu_fetch #(.RESET_PC(RESET_PC), .INST_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mpc = RESET_PC;     // architectural PC the fetch unit must be working on
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  int          lat = 1;
  bit          prev_rv = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  int          since_out = 0;
  bit          abort = 1'b0;
  logic [31:0] req_log[$];
  logic [31:0] out_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rq(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] oq(input int i);
    return (i < out_log.size()) ? out_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit misal;
    misal = MISAL_EN && (mpc[1:0] != 2'b00);
    if (out_valid) begin
      since_out = 0;
      chk("out_pc", out_pc, mpc);
      chk("out_inst", out_inst, misal ? 32'd0 : memf(mpc));
      chk("out_fault", {31'd0, out_fault}, {31'd0, misal});
    end else begin
      since_out++;
      if (since_out == 400) begin
        checks++;
        failures++;
        abort = 1'b1;
        $display("FAIL watchdog: %0d cycles without out_valid, limit 400", since_out);
      end
    end
    if (imem_req_valid) begin
      chk("single_outstanding", {31'd0, mem_pend}, 32'd0);
      chk("req_during_out_valid", {31'd0, out_valid}, 32'd0);
      if (!prev_rv) begin
        chk("req_addr_start", imem_req_addr, mpc);
`ifdef YSYX_22050854_IFU_MISALIGN_EN
        chk("req_misaligned", {31'd0, misal}, 32'd0);
`endif
      end else if (!prev_hs) begin
        chk("req_addr_stable", imem_req_addr, prev_addr);
      end
    end
  endtask

  // One clock: account for this cycle's handshakes, advance, then check the new outputs.
  task automatic tick();
    bit hs;
    hs = imem_req_valid && imem_req_ready;
    if (hs) req_log.push_back(imem_req_addr);
    if (out_valid && out_ready) out_log.push_back(out_pc);
    if (imem_resp_valid) mem_pend = 1'b0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (hs) begin
      mem_pend = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = lat - 1;
    end
    if (redirect_valid) mpc = redirect_pc;
    else if (out_valid && out_ready) mpc = mpc + 32'd4;
    prev_rv   = imem_req_valid;
    prev_hs   = hs;
    prev_addr = imem_req_addr;
    @(posedge clk);
    #1;
    redirect_valid  = 1'b0;
    imem_resp_valid = mem_pend && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? memf(mem_addr) : $urandom;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_fault", {31'd0, out_fault}, 32'd0);
    mpc = RESET_PC;
    mem_pend = 1'b0;
    prev_rv = 1'b0;
    prev_hs = 1'b0;
    since_out = 0;
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    req_log.delete();
    out_log.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic until_out_valid(input string tag);
    for (int i = 0; i < 60 && !out_valid; i++) tick();
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic until_reqs(input int n, input string tag);
    for (int i = 0; i < 80 && req_log.size() < n; i++) tick();
    chk(tag, {31'd0, req_log.size() >= n}, 32'd1);
  endtask

  task automatic until_outs(input int n, input string tag);
    for (int i = 0; i < 80 && out_log.size() < n; i++) tick();
    chk(tag, {31'd0, out_log.size() >= n}, 32'd1);
  endtask

  initial begin
    int n, o, cnt;
    #2;
    do_reset();

    // sequential fetch, always-ready memory with 1-cycle response
    imem_req_ready = 1'b1; out_ready = 1'b1; lat = 1;
    cnt = 0;
    while (!out_valid && cnt < 20) begin tick(); cnt++; end
    chk("A_first_out_latency", cnt, 3);
    until_outs(3, "A_outs_timeout");
    chk("A_req0", rq(0), 32'h8000_0000);
    chk("A_req1", rq(1), 32'h8000_0004);
    chk("A_req2", rq(2), 32'h8000_0008);
    chk("A_out0", oq(0), 32'h8000_0000);
    chk("A_out1", oq(1), 32'h8000_0004);
    chk("A_out2", oq(2), 32'h8000_0008);

    // decode stalls for 5 cycles in HOLD
    out_ready = 1'b0;
    until_out_valid("B_out_valid_timeout");
    n = req_log.size();
    repeat (5) begin
      tick();
      chk("B_hold_pc", out_pc, 32'h8000_000C);
    end
    chk("B_no_req_while_hold", req_log.size(), n);
    out_ready = 1'b1;

    // redirect while the request is stalled by memory
    do_reset();
    out_ready = 1'b1; imem_req_ready = 1'b0;
    for (int i = 0; i < 10 && !imem_req_valid; i++) tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    tick();
    tick();
    imem_req_ready = 1'b1;
    until_outs(1, "C_outs_timeout");
    chk("C_req_stale", rq(0), 32'h8000_0000);
    chk("C_req_target", rq(1), 32'h8000_1000);
    chk("C_first_out", oq(0), 32'h8000_1000);

    // redirect in WAIT coinciding with the response
    n = req_log.size();
    until_reqs(n + 1, "D_req_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    o = out_log.size();
    until_outs(o + 1, "D_outs_timeout");
    chk("D_req_target", rq(n + 1), 32'h8000_0200);
    chk("D_first_out", oq(o), 32'h8000_0200);

    // redirect in HOLD together with out_ready: no +4
    out_ready = 1'b0;
    until_out_valid("E_out_valid_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040; out_ready = 1'b1;
    n = req_log.size();
    until_reqs(n + 1, "E_req_timeout");
    chk("E_req_target", rq(n), 32'h8000_0040);

    // two back-to-back redirects during a long wait
    lat = 4;
    n = req_log.size();
    until_reqs(n + 1, "E2_req_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    o = out_log.size();
    until_outs(o + 1, "E2_outs_timeout");
    chk("E2_req_target", rq(n + 1), 32'h8000_0200);
    chk("E2_first_out", oq(o), 32'h8000_0200);

    // misaligned redirect target
    lat = 1; out_ready = 1'b0;
    until_out_valid("F_pre_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
    n = req_log.size();
    tick();
    until_out_valid("F_out_valid_timeout");
    chk("F_out_pc", out_pc, 32'h8000_0002);
`ifdef YSYX_22050854_IFU_MISALIGN_EN
    chk("F_fault", {31'd0, out_fault}, 32'd1);
    chk("F_inst_zero", out_inst, 32'd0);
    chk("F_no_req", req_log.size(), n);
`else
    chk("F_fault", {31'd0, out_fault}, 32'd0);
    chk("F_req_addr", rq(n), 32'h8000_0002);
`endif
    out_ready = 1'b1;

    // random traffic with a reset in the middle
    for (int c = 0; c < 4000 && !abort; c++) begin
      if (c == 2000) do_reset();
      imem_req_ready = ($urandom % 4) != 0;
      out_ready      = ($urandom % 10) < 7;
      lat            = $urandom_range(1, 4);
      if (($urandom % 100) < 6) begin
        redirect_valid = 1'b1;
        case ($urandom % 16)
          0:       redirect_pc = 32'hFFFF_FFFC;
          1, 2:    redirect_pc = RESET_PC + {20'd0, $urandom_range(0, 1023), 2'b00} + $urandom_range(1, 3);
          default: redirect_pc = RESET_PC + {20'd0, $urandom_range(0, 1023), 2'b00};
        endcase
      end
      tick();
    end
    chk("rand_progress", {31'd0, out_log.size() >= 50}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded 1000000 time units");
    $fatal(1, "global timeout");
  end

endmodule
